// File: rtl/fir_stream_ctrl.sv
// Stream sequencer for the fir_filter datapath: feeds x/ce, tracks in-flight results by credit,
// captures y into an output FIFO and drains the delay line with TAPS zeros on flush.
module fir_stream_ctrl #(
  parameter int DW        = 8,
  parameter int YW        = 16,
  parameter int TAPS      = 4,
  parameter int FIR_LAT   = 1,
  parameter int OUT_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          flush_req,
  output logic          flush_busy,
  output logic          flush_done,
  output logic [DW-1:0] fir_x,
  output logic          fir_ce,
  input  logic [YW-1:0] fir_y,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [YW-1:0] m_data,
  output logic          m_last
);
  localparam int PW = $clog2(OUT_DEPTH);
  localparam int CW = PW + 1;
  localparam int ZW = $clog2(TAPS + 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(OUT_DEPTH);

  typedef enum logic [1:0] {RUN, FLUSH, DRAIN} state_t;

  state_t               state, state_nxt;
  logic [ZW-1:0]        zero_cnt, zero_cnt_nxt;
  logic [CW-1:0]        fifo_count, inflight;
  logic [CW:0]          used;
  logic                 credit, push, push_last, cap, cap_last, wr, rd, fir_last;
  logic [DW-1:0]        push_x;
  logic [FIR_LAT-1:0]   vld_pipe, last_pipe;
  logic [YW-1:0]        mem_y [OUT_DEPTH];
  logic [OUT_DEPTH-1:0] mem_last;
  logic [PW-1:0]        wr_ptr, rd_ptr;

  // Results already queued plus results still inside the filter may never exceed the FIFO.
  assign used   = {1'b0, fifo_count} + {1'b0, inflight};
  assign credit = used < DEPTH_C;

  always_comb begin
    state_nxt    = state;
    zero_cnt_nxt = zero_cnt;
    s_ready      = 1'b0;
    push         = 1'b0;
    push_last    = 1'b0;
    push_x       = s_data;
    flush_done   = 1'b0;
    case (state)
      RUN: begin
        s_ready = credit && !flush_req;
        push    = s_valid && s_ready;
        if (flush_req) begin
          state_nxt    = FLUSH;
          zero_cnt_nxt = ZW'(TAPS);
        end
      end
      FLUSH: begin
        push_x = '0;
        if (credit) begin
          push         = 1'b1;
          zero_cnt_nxt = zero_cnt - ZW'(1);
          if (zero_cnt == ZW'(1)) begin
            push_last = 1'b1;
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (inflight == '0) begin
          flush_done = 1'b1;
          state_nxt  = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
    if (!reset) begin
      s_ready    = 1'b0;
      push       = 1'b0;
      flush_done = 1'b0;
    end
  end

  assign flush_busy = reset && (state != RUN) && !flush_done;
  assign cap        = vld_pipe[FIR_LAT-1];
  assign cap_last   = last_pipe[FIR_LAT-1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= RUN;
      zero_cnt  <= '0;
      fir_x     <= '0;
      fir_ce    <= 1'b0;
      fir_last  <= 1'b0;
      vld_pipe  <= '0;
      last_pipe <= '0;
      inflight  <= '0;
    end else begin
      state     <= state_nxt;
      zero_cnt  <= zero_cnt_nxt;
      fir_ce    <= push;
      fir_last  <= push_last;
      if (push) fir_x <= push_x;
      vld_pipe[0]  <= fir_ce;
      last_pipe[0] <= fir_last;
      for (int i = 1; i < FIR_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
      if (push && !cap)      inflight <= inflight + CW'(1);
      else if (!push && cap) inflight <= inflight - CW'(1);
    end
  end

  // Output FIFO: capture is unconditional, the credit scheme guarantees room.
  assign wr      = cap;
  assign m_valid = reset && (fifo_count != '0);
  assign rd      = m_valid && m_ready;
  assign m_data  = mem_y[rd_ptr];
  assign m_last  = m_valid && mem_last[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + PW'(1);
      if (rd) rd_ptr <= rd_ptr + PW'(1);
      if (wr && !rd)      fifo_count <= fifo_count + CW'(1);
      else if (!wr && rd) fifo_count <= fifo_count - CW'(1);
      if (wr) assert ({1'b0, fifo_count} < DEPTH_C);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem_y[wr_ptr]    <= fir_y;
      mem_last[wr_ptr] <= cap_last;
    end
  end
endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Bench for fir_stream_ctrl: 4-tap unit-coefficient filter stand-in, result scoreboard
// built from the accepted-sample history, directed scenarios and a random stream phase.
module tb_fir_stream_ctrl;
  localparam int DW = 8, YW = 16, TAPS = 4, FIR_LAT = 1, OUT_DEPTH = 4;

  logic          clk = 1'b0, reset = 1'b0;
  logic          s_valid = 1'b0, flush_req = 1'b0, m_ready = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready, flush_busy, flush_done, fir_ce, m_valid, m_last;
  logic [DW-1:0] fir_x;
  logic [YW-1:0] fir_y, m_data;

  always #5 clk = ~clk;

  fir_stream_ctrl #(.DW(DW), .YW(YW), .TAPS(TAPS), .FIR_LAT(FIR_LAT), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
    .fir_x(fir_x), .fir_ce(fir_ce), .fir_y(fir_y),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  // filter stand-in: registered y = x + previous three x, advanced on fir_ce
  logic signed [DW-1:0] xs, h0, h1, h2;
  assign xs = fir_x;
  always @(posedge clk) begin
    if (!reset) begin
      h0 <= '0; h1 <= '0; h2 <= '0; fir_y <= '0;
    end else if (fir_ce) begin
      h0 <= xs; h1 <= h0; h2 <= h1;
      fir_y <= YW'(xs) + YW'(h0) + YW'(h1) + YW'(h2);
    end
  end

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // reference model: expected result queue derived from the filter's input history
  typedef struct {int y; bit last;} res_t;
  res_t expq[$];
  res_t mr;
  int   hist[$];
  int   obs_y[$], obs_cyc[$];
  bit   mbusy = 1'b0;
  int   cyc = 0, acc_cnt = 0, done_cnt = 0, zce_cnt = 0, n_last = 0, last_acc = 0;
  int   first_acc = -1, first_mv = -1;

  function automatic void feed(input int x, input bit last);
    int s = 0;
    res_t r;
    hist.push_back(x);
    if (hist.size() > TAPS) void'(hist.pop_front());
    foreach (hist[i]) s += hist[i];
    r.y = s; r.last = last;
    expq.push_back(r);
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      chk("rst_s_ready", s_ready, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_flush_done", flush_done, 0);
      hist.delete(); expq.delete();
      mbusy = 1'b0; zce_cnt = 0;
    end else begin
      if (mbusy) chk("busy_s_ready", s_ready, 0);
      if (mbusy && fir_ce) begin
        chk("flush_fir_x", int'($signed(fir_x)), 0);
        zce_cnt++;
      end
      if (flush_done) begin
        chk("done_while_busy", mbusy, 1);
        chk("done_zero_pushes", zce_cnt, TAPS);
        chk("done_busy_low", flush_busy, 0);
        mbusy = 1'b0;
        done_cnt++;
      end else begin
        chk("flush_busy", flush_busy, mbusy);
      end
      if (s_valid && s_ready) begin
        last_acc = int'($signed(s_data));
        feed(last_acc, 1'b0);
        acc_cnt++;
        if (first_acc < 0) first_acc = cyc;
      end
      if (flush_req && !mbusy) begin
        chk("flush_s_ready", s_ready, 0);
        mbusy = 1'b1; zce_cnt = 0;
        for (int k = 0; k < TAPS; k++) feed(0, k == TAPS-1);
      end
      if (m_valid && first_mv < 0) first_mv = cyc;
      if (!m_valid) chk("m_last_no_valid", m_last, 0);
      if (m_valid && m_ready) begin
        obs_y.push_back(int'($signed(m_data)));
        obs_cyc.push_back(cyc);
        if (m_last) n_last++;
        if (expq.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          mr = expq.pop_front();
          chk("m_data", int'($signed(m_data)), mr.y);
          chk("m_last", m_last, mr.last);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input int x);
    bit ok = 1'b0;
    s_valid = 1'b1; s_data = DW'(x); #1;
    for (int i = 0; i < 50 && !ok; i++) begin ok = s_ready; tick(); end
    s_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    m_ready = 1'b1;
    while ((expq.size() != 0 || mbusy || m_valid) && n < 300) begin tick(); n++; end
    chk(tag, int'(n < 300), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_t2[6] = '{1, 3, 6, 10, 14, 18};
    int exp_t4[4] = '{15, 11, 6, 0};
    int a0, d0, l0, n;
    bit a;

    // T1 reset held with s_valid asserted
    s_valid = 1'b1; s_data = 8'd9; m_ready = 1'b1;
    repeat (3) tick();
    chk("t1_s_ready", s_ready, 0);
    chk("t1_m_valid", m_valid, 0);
    chk("t1_fir_ce", fir_ce, 0);
    chk("t1_busy", flush_busy, 0);
    reset = 1'b1; s_valid = 1'b0; #1;
    chk("t1_release_s_ready", s_ready, 1);

    // T2 stream 1..6, latency and throughput
    first_acc = -1; first_mv = -1; obs_y.delete(); obs_cyc.delete();
    for (int k = 1; k <= 6; k++) send(k);
    drain("t2_drain");
    chk("t2_count", obs_y.size(), 6);
    for (int i = 0; i < 6 && i < obs_y.size(); i++) chk("t2_y", obs_y[i], exp_t2[i]);
    chk("t2_latency", first_mv - first_acc, FIR_LAT + 2);
    if (obs_cyc.size() == 6) chk("t2_back_to_back", obs_cyc[5] - obs_cyc[0], 5);

    // T3 backpressure: only OUT_DEPTH accepted while m_ready low
    obs_y.delete(); a0 = acc_cnt; m_ready = 1'b0;
    s_valid = 1'b1; s_data = DW'($urandom);
    repeat (12) begin #1; a = s_ready; tick(); if (a) s_data = DW'($urandom); end
    chk("t3_accepted", acc_cnt - a0, OUT_DEPTH);
    chk("t3_s_ready", s_ready, 0);
    m_ready = 1'b1; n = 0;
    while (acc_cnt - a0 < 8 && n < 100) begin #1; a = s_ready; tick(); n++; if (a) s_data = DW'($urandom); end
    s_valid = 1'b0;
    drain("t3_drain");
    chk("t3_delivered", obs_y.size(), 8);

    // T4 flush after 1..6
    obs_y.delete(); d0 = done_cnt; l0 = n_last;
    for (int k = 1; k <= 6; k++) send(k);
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    drain("t4_drain");
    chk("t4_count", obs_y.size(), 10);
    for (int i = 0; i < 4 && obs_y.size() == 10; i++) chk("t4_flush_y", obs_y[6+i], exp_t4[i]);
    chk("t4_done_pulses", done_cnt - d0, 1);
    chk("t4_last_count", n_last - l0, 1);

    // T5 flush_req with a simultaneous sample; second flush_req during DRAIN
    d0 = done_cnt; a0 = acc_cnt;
    s_valid = 1'b1; s_data = 8'd7; flush_req = 1'b1; #1;
    chk("t5_s_ready", s_ready, 0);
    tick(); flush_req = 1'b0;
    repeat (4) tick();
    if (mbusy) begin flush_req = 1'b1; tick(); flush_req = 1'b0; end
    n = 0;
    while (done_cnt == d0 && n < 50) begin tick(); n++; end
    chk("t5_done", done_cnt - d0, 1);
    chk("t5_held", acc_cnt - a0, 0);
    n = 0;
    while (acc_cnt == a0 && n < 20) begin tick(); n++; end
    s_valid = 1'b0;
    chk("t5_accepted_after", acc_cnt - a0, 1);
    chk("t5_data", last_acc, 7);
    drain("t5_drain");
    chk("t5_drain_flush_ignored", done_cnt - d0, 1);

    // T6 reset in the middle of a flush
    send(10); send(20); send(30);
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    n = 0;
    while (zce_cnt < 1 && n < 20) begin tick(); n++; end
    d0 = done_cnt;
    reset = 1'b0;
    repeat (2) tick();
    chk("t6_m_valid", m_valid, 0);
    chk("t6_busy", flush_busy, 0);
    reset = 1'b1; #1;
    chk("t6_run_s_ready", s_ready, 1);
    chk("t6_run_busy", flush_busy, 0);
    repeat (5) tick();
    chk("t6_no_done", done_cnt - d0, 0);
    chk("t6_fifo_empty", m_valid, 0);

    // random stream with random backpressure and flush requests
    a = 1'b0;
    for (int c = 0; c < 600; c++) begin
      m_ready   = ($urandom_range(0, 9) < 6);
      flush_req = ($urandom_range(0, 39) == 0);
      if (!s_valid || a) begin
        s_valid = ($urandom_range(0, 9) < 7);
        s_data  = DW'($urandom);
      end
      #1; a = s_valid && s_ready;
      tick();
    end
    flush_req = 1'b0; s_valid = 1'b0;
    drain("rand_drain");
    chk("rand_queue_empty", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
